// File: rtl/float_to_int.sv
// float_to_int: multi-cycle IEEE-754 single to signed int32 converter, truncating toward zero.
// Start/valid handshake; magnitude is aligned one bit per cycle.
module float_to_int #(
    parameter int BIAS  = 127,
    parameter int INT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      X,
    output logic [INT_W-1:0] result,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    localparam logic [7:0] B = 8'(BIAS);
    localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    state_t           state;
    logic             sign;
    logic             dir;
    logic [7:0]       expo;
    logic [22:0]      frac;
    logic [INT_W-1:0] mag;
    logic [4:0]       cnt;
    logic [7:0]       u;
    assign u    = expo - B;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sign     <= 1'b0;
            dir      <= 1'b0;
            expo     <= '0;
            frac     <= '0;
            mag      <= '0;
            cnt      <= '0;
            result   <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sign  <= X[31];
                    expo  <= X[30:23];
                    frac  <= X[22:0];
                    state <= LOAD;
                end
                LOAD: if (expo < B) begin
                    result   <= '0;
                    overflow <= 1'b0;
                    valid    <= 1'b1;
                    state    <= IDLE;
                end else if (expo >= B + 8'd31) begin
                    // exactly -2^31 is representable; everything else saturates
                    result   <= sign ? INT_MIN : INT_MAX;
                    overflow <= !(sign && expo == B + 8'd31 && frac == '0);
                    valid    <= 1'b1;
                    state    <= IDLE;
                end else begin
                    mag   <= {{(INT_W-24){1'b0}}, 1'b1, frac};
                    dir   <= u >= 8'd23;
                    cnt   <= u >= 8'd23 ? 5'(u - 8'd23) : 5'(8'd23 - u);
                    state <= SHIFT;
                end
                SHIFT: if (cnt != '0) begin
                    mag <= dir ? mag << 1 : mag >> 1;
                    cnt <= cnt - 5'd1;
                end else begin
                    result   <= sign ? -mag : mag;
                    overflow <= 1'b0;
                    valid    <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_float_to_int.sv
// tb_float_to_int: randomized and directed checks of float_to_int against a real-arithmetic model.
module tb_float_to_int;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] X = '0;
    logic [31:0] result;
    logic        valid;
    logic        overflow;
    logic        busy;
    int          total = 0;
    int          passed = 0;

    float_to_int dut (
        .clk(clk), .rst(rst), .start(start), .X(X),
        .result(result), .valid(valid), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) $display("FAIL %s: got %h, expected %h", tag, got, want);
        else passed++;
    endtask

    // Value from the IEEE fields with real arithmetic, then truncate or saturate.
    task automatic model(input logic [31:0] x, output logic [31:0] res, output logic ovf, output int lat);
        int  e;
        real r;
        e = int'(x[30:23]);
        r = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        if (x[31]) r = -r;
        if (e == 255 || r >= 2147483648.0 || r < -2147483648.0) begin
            res = x[31] ? 32'h80000000 : 32'h7FFFFFFF;
            ovf = 1'b1;
        end else begin
            res = 32'($rtoi(r));
            ovf = 1'b0;
        end
        if (e < 127 || e >= 158) lat = 1;
        else lat = (e >= 150 ? e - 150 : 150 - e) + 2;
    endtask

    // Called #1 after a rising edge; that next edge is edge 0.
    task automatic convert(input logic [31:0] x, input string tag, input bit poke_busy,
                           input bit chain, input logic [31:0] next_x);
        logic [31:0] want;
        logic        want_ovf;
        int          lat;
        int          n;
        int          pulses;
        model(x, want, want_ovf, lat);
        start = 1'b1;
        X = x;
        @(posedge clk);
        #1;
        start = 1'b0;
        X = $urandom;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!valid && n < 40) begin
            start = poke_busy && n == 3;
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        chk({tag, " latency"}, n, lat);
        chk({tag, " result"}, result, want);
        chk({tag, " overflow"}, 32'(overflow), 32'(want_ovf));
        chk({tag, " idle"}, 32'(busy), 32'd0);
        if (chain) begin
            convert(next_x, {tag, " chained"}, 1'b0, 1'b0, '0);
        end else if (poke_busy) begin
            pulses = 0;
            for (int i = 0; i < 30; i++) begin
                @(posedge clk);
                #1;
                if (valid) pulses++;
            end
            chk({tag, " extra pulses"}, pulses, 0);
        end
    endtask

    initial begin
        logic [31:0] xr;
        int          pulses;
        #1;
        chk("reset result", result, 32'd0);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        convert(32'h3F800000, "1.0", 1'b0, 1'b0, '0);
        convert(32'h40300000, "2.75", 1'b0, 1'b0, '0);
        convert(32'hC0300000, "-2.75", 1'b0, 1'b0, '0);
        convert(32'h4B800000, "2^24", 1'b0, 1'b0, '0);
        convert(32'hC1200000, "-10", 1'b0, 1'b0, '0);
        convert(32'h4F000000, "2^31", 1'b0, 1'b0, '0);
        convert(32'hCF000000, "-2^31", 1'b0, 1'b0, '0);
        convert(32'h7FC00000, "NaN", 1'b0, 1'b0, '0);
        convert(32'hFF800000, "-inf", 1'b0, 1'b0, '0);
        convert(32'h3F000000, "0.5", 1'b0, 1'b0, '0);
        convert(32'h00000001, "denormal", 1'b0, 1'b0, '0);
        convert(32'h80000000, "-0", 1'b0, 1'b0, '0);
        convert(32'h4EFFFFFF, "max normal", 1'b0, 1'b0, '0);
        convert(32'hCF000001, "below -2^31", 1'b0, 1'b0, '0);
        convert(32'h41200000, "start while busy", 1'b1, 1'b0, '0);
        convert(32'h40300000, "back-to-back", 1'b0, 1'b1, 32'h40000000);
        for (int i = 0; i < 200; i++) begin
            xr = $urandom;
            if (i % 4 != 0) xr[30:23] = 8'($urandom_range(120, 160));
            convert(xr, $sformatf("rand%0d %h", i, xr), 1'b0, 1'b0, '0);
        end
        // abort mid-conversion with a nonzero previous result
        convert(32'h42F60000, "pre-abort", 1'b0, 1'b0, '0);
        start = 1'b1;
        X = 32'h3F800000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort result", result, 32'd0);
        chk("abort valid", 32'(valid), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (valid || busy) pulses++;
        end
        chk("abort no completion", pulses, 0);
        convert(32'hC1200000, "after abort", 1'b0, 1'b0, '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
